pixel_framebuffer: RTL and testbench

//  Receiving end of the GUI pixel-plot interface (plot, x, y, colour).

---
 rtl/pixel_framebuffer.sv | 184 ++++++++++++++++++
 tb/tb_pixel_framebuffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_framebuffer.sv
// pixel_framebuffer
// Colour memory behind the pixel-plot interface. Plotted pixels are written
// into a WIDTH x HEIGHT array and the array is scanned back out in raster
// order as a valid/ready stream. After reset, and whenever clear is pulsed
// while scanning, the whole array is refilled with CLEAR_COLOUR.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | filling memory with CLEAR_COLOUR, one address per cycle;
//          | plots are dropped and no pixels are issued
// ST_SCAN  | plots are written; pixels are issued while scan_en is high

module pixel_framebuffer #(
    parameter int unsigned              WIDTH        = 160,
    parameter int unsigned              HEIGHT       = 120,
    parameter int unsigned              COLOUR_BITS  = 3,
    parameter int unsigned              ADDR_BITS    = 15,
    parameter logic [COLOUR_BITS-1:0]   CLEAR_COLOUR = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   plot,
    input  logic [7:0]             x,
    input  logic [6:0]             y,
    input  logic [COLOUR_BITS-1:0] colour_in,
    input  logic                   clear,
    input  logic                   scan_en,
    output logic                   busy,
    output logic                   wr_dropped,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_x,
    output logic [6:0]             out_y,
    output logic [COLOUR_BITS-1:0] out_colour,
    output logic                   out_frame_start
);

    localparam int unsigned            PIXELS    = WIDTH * HEIGHT;
    localparam logic [ADDR_BITS-1:0]   LAST_ADDR = ADDR_BITS'(PIXELS - 1);
    localparam logic [ADDR_BITS-1:0]   WIDTH_A   = ADDR_BITS'(WIDTH);
    localparam logic [ADDR_BITS-1:0]   ONE_A     = ADDR_BITS'(1);
    localparam logic [7:0]             LAST_X    = 8'(WIDTH - 1);
    localparam logic [6:0]             LAST_Y    = 7'(HEIGHT - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_BITS-1:0]   clear_addr;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [COLOUR_BITS-1:0] mem_wdata;
    logic                   mem_we;
    logic [7:0]             sx;
    logic [6:0]             sy;
    logic                   in_range;
    logic                   plot_ok;
    logic                   flush;
    logic                   issue;

    logic [COLOUR_BITS-1:0] mem [0:PIXELS-1];

    // Addresses are formed at full ADDR_BITS width so y*WIDTH never truncates.
    assign in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign wr_addr  = ADDR_BITS'(y) * WIDTH_A + ADDR_BITS'(x);
    assign rd_addr  = ADDR_BITS'(sy) * WIDTH_A + ADDR_BITS'(sx);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state: clear runs to the last address; a clear request restarts it
    // only from SCAN, so a request during an active clear is ignored.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: begin
                if (clear_addr == LAST_ADDR) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (clear) begin
                    state_next = ST_CLEAR;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // State-derived controls and the single memory write port mux
    always_comb begin
        busy      = (state == ST_CLEAR);
        flush     = (state == ST_SCAN) && clear;
        plot_ok   = (state == ST_SCAN) && plot && in_range;
        issue     = (state == ST_SCAN) && !clear && scan_en && (!out_valid || out_ready);
        mem_we    = reset && (busy || plot_ok);
        mem_addr  = wr_addr;
        mem_wdata = colour_in;
        if (busy) begin
            mem_addr  = clear_addr;
            mem_wdata = CLEAR_COLOUR;
        end
    end

    // Clear address walks the array in CLEAR and parks at 0 otherwise,
    // so every clear sequence starts from address 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clear_addr <= '0;
        end else if (state == ST_CLEAR) begin
            if (clear_addr == LAST_ADDR) begin
                clear_addr <= '0;
            end else begin
                clear_addr <= clear_addr + ONE_A;
            end
        end else begin
            clear_addr <= '0;
        end
    end

    // Colour memory write port (not reset; contents come from the clear sequence)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Dropped-plot flag: one cycle after a plot that could not be written
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_dropped <= 1'b0;
        end else begin
            wr_dropped <= plot && (busy || !in_range);
        end
    end

    // Scan-out: registered read of the scan address, output register held
    // under back-pressure, flushed when a clear request arrives in SCAN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid       <= 1'b0;
            out_x           <= '0;
            out_y           <= '0;
            out_colour      <= '0;
            out_frame_start <= 1'b0;
            sx              <= '0;
            sy              <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            sx        <= '0;
            sy        <= '0;
        end else if (issue) begin
            out_colour      <= mem[rd_addr];
            out_x           <= sx;
            out_y           <= sy;
            out_frame_start <= (sx == 8'd0) && (sy == 7'd0);
            out_valid       <= 1'b1;
            if (sx == LAST_X) begin
                sx <= '0;
                if (sy == LAST_Y) begin
                    sy <= '0;
                end else begin
                    sy <= sy + 7'd1;
                end
            end else begin
                sx <= sx + 8'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_framebuffer.sv
// tb_pixel_framebuffer
// Randomized plot/scan traffic against a frame-level model: a colour array,
// a raster index of the next pixel the consumer should receive, and a
// cycle count of the remaining clear time.

module tb_pixel_framebuffer;

    localparam int       W   = 160;
    localparam int       H   = 120;
    localparam int       N   = W * H;
    localparam logic [2:0] CLR = 3'b000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       plot = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour_in = '0;
    logic       clear = 1'b0;
    logic       scan_en = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       wr_dropped;
    logic       out_valid;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_frame_start;

    pixel_framebuffer #(
        .WIDTH(W), .HEIGHT(H), .COLOUR_BITS(3), .ADDR_BITS(15), .CLEAR_COLOUR(CLR)
    ) dut (
        .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour_in(colour_in),
        .clear(clear), .scan_en(scan_en), .busy(busy), .wr_dropped(wr_dropped),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_colour(out_colour), .out_frame_start(out_frame_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    logic [2:0] mdl_mem [N];
    int   busy_left = N;
    int   p = 0;
    int   hs_cnt = 0;
    int   fs_cnt = 0;
    int   nonclr_cnt = 0;
    bit   exp_valid = 0;
    bit   exp_drop = 0;
    bit   prev_stall = 0;
    bit   override0 = 0;
    bit   frame3 = 0;
    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_c;
    logic       px_fs;
    int   seen325 = -1;
    int   p2_x = -1, p2_y = -1, p2_fs = -1, p2_c = -1;

    // Single compare process: every cycle, outputs against the model
    always @(negedge clk) begin
        bit eb, fl, iss;
        logic [2:0] ec;
        if (!reset) begin
            busy_left  = N;
            p          = 0;
            exp_valid  = 0;
            exp_drop   = 0;
            prev_stall = 0;
            for (int i = 0; i < N; i++) mdl_mem[i] = CLR;
        end else begin
            eb = (busy_left > 0);
            chk("busy", busy, eb);
            chk("wr_dropped", wr_dropped, exp_drop);
            chk("out_valid", out_valid, exp_valid);
            if (prev_stall) begin
                chk("hold_x", out_x, px_x);
                chk("hold_y", out_y, px_y);
                chk("hold_colour", out_colour, px_c);
                chk("hold_fs", out_frame_start, px_fs);
            end
            if (exp_valid && out_ready) begin
                ec = mdl_mem[p];
                if (p == 0 && override0) begin
                    ec = CLR;
                    override0 = 0;
                end
                chk("pix_x", out_x, p % W);
                chk("pix_y", out_y, p / W);
                chk("pix_fs", out_frame_start, (p == 0));
                chk("pix_colour", out_colour, ec);
                if (out_frame_start) fs_cnt++;
                if (p == 325) seen325 = out_colour;
                if (hs_cnt == N) begin
                    p2_x = out_x; p2_y = out_y; p2_fs = out_frame_start; p2_c = out_colour;
                end
                if (frame3 && out_colour != CLR) nonclr_cnt++;
                hs_cnt++;
                p = (p + 1) % N;
            end
            fl  = clear && !eb;
            iss = !eb && !clear && scan_en && (!exp_valid || out_ready);
            prev_stall = exp_valid && !out_ready && !fl;
            px_x = out_x; px_y = out_y; px_c = out_colour; px_fs = out_frame_start;
            if (fl)            exp_valid = 0;
            else if (iss)      exp_valid = 1;
            else if (out_ready) exp_valid = 0;
            exp_drop = plot && (eb || int'(x) >= W || int'(y) >= H);
            if (plot && !exp_drop) mdl_mem[int'(y) * W + int'(x)] = colour_in;
            if (fl) begin
                p = 0;
                busy_left = N;
                for (int i = 0; i < N; i++) mdl_mem[i] = CLR;
            end else if (busy_left > 0) begin
                busy_left--;
            end
        end
    end

    task automatic tick_set(input bit pl, input int xx, input int yy, input int cc);
        @(posedge clk); #1;
        plot = pl; x = 8'(xx); y = 7'(yy); colour_in = 3'(cc);
    endtask

    // Out-of-range plot on the current cycle
    task automatic set_oor_plot();
        plot = 1'b1;
        colour_in = 3'($urandom);
        if ($urandom % 2 == 0) begin
            x = 8'($urandom_range(160, 255)); y = 7'($urandom_range(0, 127));
        end else begin
            x = 8'($urandom_range(0, 255));   y = 7'($urandom_range(120, 127));
        end
    endtask

    // In-range plot away from the pinned pixels and from the scan position
    task automatic set_inrange_plot();
        int xx, yy, a, d;
        do begin
            xx = $urandom_range(0, W - 1);
            yy = $urandom_range(0, H - 1);
            a  = yy * W + xx;
            d  = (a - p + N) % N;
        end while (a == 0 || a == 325 || d < 4 || d > N - 4);
        plot = 1'b1; x = 8'(xx); y = 7'(yy); colour_in = 3'($urandom);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, f3, stall_left;
        bit stall_done;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_wr_dropped", wr_dropped, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_colour", out_colour, 0);
        chk("rst_frame_start", out_frame_start, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Initial clear: dropped plots and ignored clear pulses
        cnt = 0;
        for (int c = 0; c < N + 100; c++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            @(posedge clk); #1;
            if (cnt < N - 10) begin
                plot = ($urandom % 3 == 0);
                x = 8'($urandom); y = 7'($urandom); colour_in = 3'($urandom);
                clear = ($urandom % 50 == 0);
            end else begin
                plot = 1'b0; clear = 1'b0;
            end
        end
        chk("init_busy_cycles", cnt, N);

        // Directed plots with the scan held off
        tick_set(1, 5, 2, 6);
        tick_set(1, 160, 0, 0);
        tick_set(0, 0, 0, 0);
        @(negedge clk) chk("drop_x160", wr_dropped, 1);
        tick_set(1, 0, 120, 0);
        tick_set(0, 0, 0, 0);
        @(negedge clk) chk("drop_y120", wr_dropped, 1);
        repeat (40) begin
            @(posedge clk); #1;
            if ($urandom % 4 == 0) set_oor_plot();
            else                   set_inrange_plot();
        end

        // Start the scan in the same cycle (0,0) is overwritten: first read is old
        @(posedge clk); #1;
        plot = 1'b1; x = 8'd0; y = 7'd0; colour_in = 3'd7;
        scan_en = 1'b1; out_ready = 1'b1; override0 = 1'b1;

        // Frame 1: random back-pressure, scan gating and plots
        stall_left = 0;
        stall_done = 0;
        for (int c = 0; c < 45000 && hs_cnt < N; c++) begin
            @(posedge clk); #1;
            plot = 1'b0;
            if (!stall_done && hs_cnt >= 1005) begin
                stall_left = 3;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0; scan_en = 1'b1; stall_left--;
            end else begin
                out_ready = ($urandom % 8 != 0);
                scan_en   = ($urandom % 16 != 0);
            end
            case ($urandom % 8)
                0: set_inrange_plot();
                1: set_oor_plot();
                default: ;
            endcase
        end
        chk("frame1_done", (hs_cnt >= N), 1);
        chk("pix325_colour", seen325, 6);

        // Frame 2 start: wrap to (0,0)
        for (int c = 0; c < 2000 && hs_cnt < N + 200; c++) begin
            @(posedge clk); #1;
            plot = 1'b0; out_ready = 1'b1; scan_en = 1'b1;
        end
        chk("p19201_x", p2_x, 0);
        chk("p19201_y", p2_y, 0);
        chk("p19201_fs", p2_fs, 1);
        chk("p19201_colour", p2_c, 7);
        chk("frame_start_count", fs_cnt, 2);

        // Clear mid-scan
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_busy", busy, 1);
        cnt = 1;
        for (int c = 0; c < N + 100; c++) begin
            @(posedge clk); #1;
            if (cnt < N - 10) begin
                if ($urandom % 2 == 0) set_inrange_plot(); else plot = 1'b0;
                clear     = ($urandom % 60 == 0);
                out_ready = ($urandom % 2 == 0);
            end else begin
                plot = 1'b0; clear = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk("clear_busy_cycles", cnt, N);

        // Frame 3: everything reads back the clear colour
        f3 = hs_cnt;
        frame3 = 1'b1;
        nonclr_cnt = 0;
        for (int c = 0; c < N + 1000 && hs_cnt < f3 + N; c++) begin
            @(posedge clk); #1;
            plot = 1'b0; out_ready = 1'b1; scan_en = 1'b1;
        end
        frame3 = 1'b0;
        chk("frame3_done", (hs_cnt >= f3 + N), 1);
        chk("frame3_nonclear", nonclr_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
